// File: rtl/i2c_index_sequencer_if.sv
// Bundles the sequencer's control inputs, limit inputs and index/flag outputs.
// No latency of its own; it is wiring only.
// No backpressure; start/step/abort are plain level strobes sampled each edge.
interface i2c_index_sequencer_if #(
  parameter int BI_BW = 3,
  parameter int MI_BW = 2,
  parameter int TI_BW = 5
);
  logic             start;
  logic             step;
  logic             abort;
  logic [BI_BW-1:0] limit_bit;
  logic [MI_BW-1:0] limit_msg;
  logic [TI_BW-1:0] limit_trans;
  logic [BI_BW-1:0] index_bit;
  logic [MI_BW-1:0] index_msg;
  logic [TI_BW-1:0] index_trans;
  logic             last_bit;
  logic             last_msg;
  logic             last_trans;
  logic             carry_msg;
  logic             carry_trans;
  logic             busy;
  logic             done;

  // Controller side: issues commands and limits, observes progress.
  modport master (
    output start, step, abort, limit_bit, limit_msg, limit_trans,
    input  index_bit, index_msg, index_trans, last_bit, last_msg, last_trans,
           carry_msg, carry_trans, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, step, abort, limit_bit, limit_msg, limit_trans,
    output index_bit, index_msg, index_trans, last_bit, last_msg, last_trans,
           carry_msg, carry_trans, busy, done
  );
endinterface

// File: rtl/i2c_index_sequencer.sv
// Three-level bit/message/transaction index counter with latched limits and carries.
// Steps land on index_* at the sampling edge; last/carry flags are combinational.
// No backpressure: each step in RUN is always accepted; abort overrides step/start.
module i2c_index_sequencer #(
  parameter int BI_BW = 3,
  parameter int MI_BW = 2,
  parameter int TI_BW = 5
) (
  input  logic clock,
  input  logic reset,
  i2c_index_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [BI_BW-1:0] idx_bit;
  logic [MI_BW-1:0] idx_msg;
  logic [TI_BW-1:0] idx_trans;
  logic [BI_BW-1:0] lim_bit;
  logic [MI_BW-1:0] lim_msg;
  logic [TI_BW-1:0] lim_trans;
  logic             done_q;

  logic hit_bit;
  logic hit_msg;
  logic hit_trans;
  logic adv;
  logic wrap_bit;
  logic wrap_msg;
  logic finish;

  // Limits are compared against the shadow copies so mid-run limit changes are invisible.
  assign hit_bit   = (idx_bit   == lim_bit);
  assign hit_msg   = (idx_msg   == lim_msg);
  assign hit_trans = (idx_trans == lim_trans);

  // A step only counts in RUN, and abort wins over it.
  assign adv      = (state == ST_RUN) && bus.step && !bus.abort;
  assign wrap_bit = adv && hit_bit;
  assign wrap_msg = wrap_bit && hit_msg;
  assign finish   = wrap_msg && hit_trans;

  assign bus.index_bit   = idx_bit;
  assign bus.index_msg   = idx_msg;
  assign bus.index_trans = idx_trans;
  assign bus.last_bit    = hit_bit;
  assign bus.last_msg    = hit_msg;
  assign bus.last_trans  = hit_trans;
  assign bus.carry_msg   = wrap_bit;
  assign bus.carry_trans = wrap_msg;
  assign bus.busy        = (state == ST_RUN);
  assign bus.done        = done_q;

  // FSM, index counters, shadow limits and the one-cycle done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx_bit   <= '0;
      idx_msg   <= '0;
      idx_trans <= '0;
      lim_bit   <= '0;
      lim_msg   <= '0;
      lim_trans <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            lim_bit   <= bus.limit_bit;
            lim_msg   <= bus.limit_msg;
            lim_trans <= bus.limit_trans;
            idx_bit   <= '0;
            idx_msg   <= '0;
            idx_trans <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            idx_bit   <= '0;
            idx_msg   <= '0;
            idx_trans <= '0;
            state     <= ST_IDLE;
          end else if (bus.step) begin
            if (!hit_bit) begin
              idx_bit <= idx_bit + BI_BW'(1);
            end else begin
              idx_bit <= '0;
              if (!hit_msg) begin
                idx_msg <= idx_msg + MI_BW'(1);
              end else begin
                idx_msg <= '0;
                if (!hit_trans) begin
                  idx_trans <= idx_trans + TI_BW'(1);
                end else begin
                  // Final step of the sequence: everything is back at zero.
                  idx_trans <= '0;
                  state     <= ST_DONE;
                  done_q    <= 1'b1;
                end
              end
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_index_sequencer.sv
// Randomised and directed stimulus checked by a scoreboard against a step-count model.
// Expected outputs are queued per cycle by the driver; a monitor pops them at negedge.
// The model tracks only a linear step count and derives indices by division.
module tb_i2c_index_sequencer;

  logic clk;
  logic rst;

  i2c_index_sequencer_if #(.BI_BW(3), .MI_BW(2), .TI_BW(5)) bus ();

  i2c_index_sequencer #(.BI_BW(3), .MI_BW(2), .TI_BW(5)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ib;
    logic [1:0] im;
    logic [4:0] it;
    logic       lb;
    logic       lm;
    logic       lt;
    logic       cm;
    logic       ct;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t expq[$];
  int   n_checks;
  int   n_fail;

  // Reference model: mode 0 idle, 1 run, 2 done; k = accepted steps so far.
  int mode;
  int k;
  int sb, sm, st;
  int cur_lb, cur_lm, cur_lt;
  logic p_start, p_step, p_abort;
  int p_lb, p_lm, p_lt;

  function automatic obs_t predict(logic s_start, logic s_step, logic s_abort);
    obs_t o;
    int b, m, t;
    b = k % (sb + 1);
    m = (k / (sb + 1)) % (sm + 1);
    t = k / ((sb + 1) * (sm + 1));
    o.ib   = 3'(b);
    o.im   = 2'(m);
    o.it   = 5'(t);
    o.lb   = (b == sb);
    o.lm   = (m == sm);
    o.lt   = (t == st);
    o.cm   = (mode == 1) && s_step && !s_abort && (b == sb);
    o.ct   = o.cm && (m == sm);
    o.busy = (mode == 1);
    o.done = (mode == 2);
    if (s_start) o.busy = o.busy;
    return o;
  endfunction

  task automatic model_edge();
    case (mode)
      0: if (p_start && !p_abort) begin
        sb = p_lb; sm = p_lm; st = p_lt;
        k = 0;
        mode = 1;
      end
      1: if (p_abort) begin
        mode = 0;
        k = 0;
      end else if (p_step) begin
        k++;
        if (k == (sb + 1) * (sm + 1) * (st + 1)) begin
          k = 0;
          mode = 2;
        end
      end
      default: mode = 0;
    endcase
  endtask

  task automatic drive(logic s_start, logic s_step, logic s_abort);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    bus.start       = s_start;
    bus.step        = s_step;
    bus.abort       = s_abort;
    bus.limit_bit   = 3'(cur_lb);
    bus.limit_msg   = 2'(cur_lm);
    bus.limit_trans = 5'(cur_lt);
    p_start = s_start; p_step = s_step; p_abort = s_abort;
    p_lb = cur_lb; p_lm = cur_lm; p_lt = cur_lt;
    expq.push_back(predict(s_start, s_step, s_abort));
  endtask

  task automatic set_limits(int lb, int lm, int lt);
    cur_lb = lb; cur_lm = lm; cur_lt = lt;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0);
  endtask

  // Reset asserted a couple of ns after an edge, released after the following negedge.
  task automatic reset_pulse();
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b1;
    bus.start = 1'b0; bus.step = 1'b0; bus.abort = 1'b0;
    mode = 0; k = 0; sb = 0; sm = 0; st = 0;
    p_start = 1'b0; p_step = 1'b0; p_abort = 1'b0;
    expq.push_back(predict(1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a.ib = bus.index_bit;   a.im = bus.index_msg;  a.it = bus.index_trans;
        a.lb = bus.last_bit;    a.lm = bus.last_msg;   a.lt = bus.last_trans;
        a.cm = bus.carry_msg;   a.ct = bus.carry_trans;
        a.busy = bus.busy;      a.done = bus.done;
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got idx=%0d/%0d/%0d last=%b%b%b carry=%b%b busy=%b done=%b, required idx=%0d/%0d/%0d last=%b%b%b carry=%b%b busy=%b done=%b",
                   $time, a.ib, a.im, a.it, a.lb, a.lm, a.lt, a.cm, a.ct, a.busy, a.done,
                   e.ib, e.im, e.it, e.lb, e.lm, e.lt, e.cm, e.ct, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0;
    mode = 0; k = 0; sb = 0; sm = 0; st = 0;
    p_start = 1'b0; p_step = 1'b0; p_abort = 1'b0;
    p_lb = 0; p_lm = 0; p_lt = 0;
    set_limits(0, 0, 0);
    rst = 1'b1;
    bus.start = 1'b0; bus.step = 1'b0; bus.abort = 1'b0;
    bus.limit_bit = '0; bus.limit_msg = '0; bus.limit_trans = '0;

    // Reset state, then step ignored in IDLE.
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    @(negedge clk); #1; rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Full-size sequence: 8*4*32 = 1024 steps.
    set_limits(7, 3, 31);
    drive(1'b1, 1'b0, 1'b0);
    steps(1024);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // 3*1*2 = 6 steps, carries on steps 3 and 6.
    set_limits(2, 0, 1);
    drive(1'b1, 1'b0, 1'b0);
    steps(6);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // All-zero limits: one step completes.
    set_limits(0, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    steps(1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Limit change and start mid-run are ignored.
    set_limits(7, 3, 31);
    drive(1'b1, 1'b0, 1'b0);
    steps(3);
    set_limits(1, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    steps(12);

    // Abort with step and start at index 5/2/10.
    drive(1'b0, 1'b0, 1'b1);
    set_limits(7, 3, 31);
    drive(1'b1, 1'b0, 1'b0);
    steps(10 * 32 + 2 * 8 + 5);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset at index 3/1/4, then a fresh start.
    drive(1'b1, 1'b0, 1'b0);
    steps(4 * 32 + 1 * 8 + 3);
    reset_pulse();
    drive(1'b0, 1'b1, 1'b0);
    set_limits(2, 1, 0);
    drive(1'b1, 1'b0, 1'b0);
    steps(5);

    // Random sequences with noisy limits, sporadic start and abort.
    for (int s = 0; s < 20; s++) begin
      set_limits($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));
      drive(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 3) == 0)
          set_limits($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31));
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      end
    end

    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
